jtvigil_gfx_arb: RTL and testbench

- Arbiter sharing one 32-bit graphics ROM read port between two requesters: scroll tile fetch (port A) and object fetch (port B).
- Sits between the layer fetch logic and the SDRAM/ROM bank controller.
- Holds each requester's returned word and its ok flag, so that layers sample ROM data only when it belongs to their current address.
- Port A has priority. A bounded counter guarantees port B service.

---
 rtl/jtvigil_gfx_arb.sv | 153 +++++++++++++++
 tb/tb_jtvigil_gfx_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jtvigil_gfx_arb.sv
// rtl/jtvigil_gfx_arb.sv - shares one graphics ROM port between scroll (A) and object (B) fetch
// Optional JTVIGIL_ARB_CACHE_EN: per-port last-address hit returns ok without a ROM access.
module jtvigil_gfx_arb #(
  parameter int AW   = 17,
  parameter int MAXA = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic [31:0]   a_data,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic [31:0]   b_data,
  output logic          b_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok,
  output logic          starve
);

  localparam logic [3:0] MAXA4 = 4'(MAXA);

  typedef enum logic [1:0] {IDLE, REQ_A, REQ_B, SETTLE} state_t;

  state_t        st, st_nx;
  logic [3:0]    cnt;
  logic          first, starve_q;
  logic [AW-1:0] a_last, b_last;
  logic          a_hit, b_hit, a_pend, b_pend;
  logic          go_a, go_b, cap, starve_now;

`ifdef JTVIGIL_ARB_CACHE_EN
  logic a_vld, b_vld;
  assign a_hit = a_cs & a_vld & (a_addr == a_last);
  assign b_hit = b_cs & b_vld & (b_addr == b_last);
`else
  assign a_hit = 1'b0;
  assign b_hit = 1'b0;
`endif

  assign a_pend     = a_cs & ~a_ok & ~a_hit;
  assign b_pend     = b_cs & ~b_ok & ~b_hit;
  // the first REQ cycle may still see rom_ok from the previous transfer
  assign cap        = (st == REQ_A || st == REQ_B) && !first && rom_ok;
  assign starve_now = (st == IDLE) && a_pend && b_pend && (cnt >= MAXA4);
  assign starve     = starve_now | ((st == REQ_B) & starve_q);

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    go_a  = 1'b0;
    go_b  = 1'b0;
    case (st)
      IDLE: begin
        if (a_pend && b_pend) begin
          if (cnt < MAXA4) go_a = 1'b1;
          else             go_b = 1'b1;
        end else if (a_pend) begin
          go_a = 1'b1;
        end else if (b_pend) begin
          go_b = 1'b1;
        end
        if (go_a)      st_nx = REQ_A;
        else if (go_b) st_nx = REQ_B;
      end
      REQ_A, REQ_B: if (cap) st_nx = SETTLE;
      SETTLE:       st_nx = IDLE;
      default:      st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      a_data   <= '0;
      b_data   <= '0;
      a_ok     <= 1'b0;
      b_ok     <= 1'b0;
      cnt      <= 4'd0;
      first    <= 1'b0;
      starve_q <= 1'b0;
      a_last   <= '0;
      b_last   <= '0;
`ifdef JTVIGIL_ARB_CACHE_EN
      a_vld    <= 1'b0;
      b_vld    <= 1'b0;
`endif
    end else begin
      if (a_ok && (!a_cs || a_addr != a_last)) a_ok <= 1'b0;
      if (b_ok && (!b_cs || b_addr != b_last)) b_ok <= 1'b0;
      case (st)
        IDLE: begin
          if (!b_cs) cnt <= 4'd0;
`ifdef JTVIGIL_ARB_CACHE_EN
          if (a_hit) a_ok <= 1'b1;
          if (b_hit) b_ok <= 1'b1;
`endif
          first    <= 1'b1;
          starve_q <= starve_now;
          if (go_a) begin
            rom_cs   <= 1'b1;
            rom_addr <= a_addr;
          end else if (go_b) begin
            rom_cs   <= 1'b1;
            rom_addr <= b_addr;
          end
        end
        REQ_A: begin
          first <= 1'b0;
          if (cap) begin
            a_data <= rom_data;
            rom_cs <= 1'b0;
            // a requester that moved on mid-transfer gets the data but no ok
            if (a_cs && a_addr == rom_addr) begin
              a_ok   <= 1'b1;
              a_last <= rom_addr;
`ifdef JTVIGIL_ARB_CACHE_EN
              a_vld  <= 1'b1;
`endif
            end
            if (b_cs && !b_ok && cnt != 4'hf) cnt <= cnt + 4'd1;
          end
        end
        REQ_B: begin
          first <= 1'b0;
          if (cap) begin
            b_data   <= rom_data;
            rom_cs   <= 1'b0;
            cnt      <= 4'd0;
            starve_q <= 1'b0;
            if (b_cs && b_addr == rom_addr) begin
              b_ok   <= 1'b1;
              b_last <= rom_addr;
`ifdef JTVIGIL_ARB_CACHE_EN
              b_vld  <= 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtvigil_gfx_arb.sv
// tb/tb_jtvigil_gfx_arb.sv - directed self-checking bench for jtvigil_gfx_arb
module tb_jtvigil_gfx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_cs, b_cs, rom_cs, rom_ok, a_ok, b_ok, starve;
  logic [16:0] a_addr, b_addr, rom_addr;
  logic [31:0] a_data, b_data, rom_data;

  int n_chk  = 0;
  int n_pass = 0;

  logic       auto_rom  = 1'b0;
  logic       auto_bump = 1'b0;
  logic       prev_cs   = 1'b0;
  logic [9:0] gb, gs;
  int         ng = 0;

  always #5 clk = ~clk;

  jtvigil_gfx_arb dut (
    .clk(clk), .rst(rst),
    .a_cs(a_cs), .a_addr(a_addr), .a_data(a_data), .a_ok(a_ok),
    .b_cs(b_cs), .b_addr(b_addr), .b_data(b_data), .b_ok(b_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .starve(starve)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one cycle: sample at the falling edge, then drive the automatic helpers
  task automatic tick();
    @(negedge clk);
    if (rom_cs && !prev_cs && ng < 10) begin
      gb[ng] = rom_addr[15];
      gs[ng] = starve;
      ng++;
    end
    prev_cs = rom_cs;
    if (auto_bump) begin
      if (a_ok) a_addr = a_addr + 17'd1;
      if (b_ok) b_addr = b_addr + 17'd1;
    end
    if (auto_rom) begin
      rom_ok   = rom_cs;
      rom_data = 32'hC0DE0000 | 32'(rom_addr);
    end
  endtask

  task automatic wait_cs(input string tag);
    int k;
    k = 0;
    while (!rom_cs && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(rom_cs), 32'd1);
  endtask

  initial begin
    rst = 1'b1; a_cs = 1'b0; b_cs = 1'b0; a_addr = '0; b_addr = '0;
    rom_ok = 1'b0; rom_data = '0;
    repeat (3) tick();
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_a_ok", 32'(a_ok), 0);
    chk("rst_b_ok", 32'(b_ok), 0);
    chk("rst_starve", 32'(starve), 0);
    rst = 1'b0;

    // basic A transfer, rom_ok in third REQ cycle
    a_cs = 1'b1; a_addr = 17'h01234;
    tick();
    chk("t2_cs_req1", 32'(rom_cs), 1);
    chk("t2_addr_req1", 32'(rom_addr), 32'h01234);
    tick();
    chk("t2_addr_req2", 32'(rom_addr), 32'h01234);
    tick();
    rom_ok = 1'b1; rom_data = 32'hDEADBEEF;
    tick();
    rom_ok = 1'b0;
    chk("t2_a_data", a_data, 32'hDEADBEEF);
    chk("t2_a_ok", 32'(a_ok), 1);
    chk("t2_settle_cs", 32'(rom_cs), 0);
    tick();
    chk("t2_ok_hold", 32'(a_ok), 1);
    chk("t2_no_refetch", 32'(rom_cs), 0);
    a_cs = 1'b0;
    tick();
    chk("t2_ok_clear", 32'(a_ok), 0);

    // stale rom_ok held high on REQ_B entry
    b_cs = 1'b1; b_addr = 17'h00200; rom_ok = 1'b1; rom_data = 32'h11111111;
    tick();
    chk("t3_req_b", 32'(rom_addr), 32'h00200);
    tick();
    chk("t3_no_cap_cs", 32'(rom_cs), 1);
    chk("t3_no_cap_data", b_data, 0);
    rom_data = 32'h22222222;
    tick();
    rom_ok = 1'b0;
    chk("t3_cap_data", b_data, 32'h22222222);
    chk("t3_cap_ok", 32'(b_ok), 1);
    b_cs = 1'b0;
    tick(); tick();

    // address change during REQ_A
    a_addr = 17'h00010; a_cs = 1'b1;
    tick();
    chk("t4_addr1", 32'(rom_addr), 32'h00010);
    a_addr = 17'h00020;
    tick();
    rom_ok = 1'b1; rom_data = 32'hAAAA0010;
    tick();
    rom_ok = 1'b0;
    chk("t4_no_ok", 32'(a_ok), 0);
    chk("t4_data_latched", a_data, 32'hAAAA0010);
    wait_cs("t4_reissue");
    chk("t4_addr2", 32'(rom_addr), 32'h00020);
    tick();
    rom_ok = 1'b1; rom_data = 32'hAAAA0020;
    tick();
    rom_ok = 1'b0;
    chk("t4_ok", 32'(a_ok), 1);
    chk("t4_data2", a_data, 32'hAAAA0020);

    // reset during REQ_A, late rom_ok discarded
    a_addr = 17'h00030;
    wait_cs("t5_req");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_cs", 32'(rom_cs), 0);
    chk("t5_a_ok", 32'(a_ok), 0);
    chk("t5_b_ok", 32'(b_ok), 0);
    chk("t5_a_data", a_data, 0);
    rom_ok = 1'b1; rom_data = 32'h55555555;
    tick();
    tick();
    rom_ok = 1'b0;
    chk("t5_late_data", a_data, 0);
    chk("t5_late_ok", 32'(a_ok), 0);
    chk("t5_still_req", 32'(rom_cs), 1);
    rom_ok = 1'b1; rom_data = 32'h66666666;
    tick();
    rom_ok = 1'b0;
    chk("t5_new_data", a_data, 32'h66666666);
    chk("t5_new_ok", 32'(a_ok), 1);
    a_cs = 1'b0;
    tick(); tick();

    // re-request of an already served B address
    b_addr = 17'h00100; b_cs = 1'b1;
    wait_cs("t6_req");
    tick();
    rom_ok = 1'b1; rom_data = 32'h0B0B0100;
    tick();
    rom_ok = 1'b0;
    chk("t6_first_ok", 32'(b_ok), 1);
    b_cs = 1'b0;
    tick();
    chk("t6_ok_drop", 32'(b_ok), 0);
    b_cs = 1'b1;
    tick();
`ifdef JTVIGIL_ARB_CACHE_EN
    chk("t6_hit_ok", 32'(b_ok), 1);
    chk("t6_hit_no_cs", 32'(rom_cs), 0);
`else
    chk("t6_refetch_cs", 32'(rom_cs), 1);
    chk("t6_refetch_ok", 32'(b_ok), 0);
    tick();
    rom_ok = 1'b1; rom_data = 32'h0B0B0101;
    tick();
    rom_ok = 1'b0;
    chk("t6_refetch_done", 32'(b_ok), 1);
    chk("t6_refetch_data", b_data, 32'h0B0B0101);
`endif
    b_cs = 1'b0;
    tick(); tick();

    // sustained contention: A,A,A,A,B repeating
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ng = 0;
    a_addr = 17'h00400; b_addr = 17'h08000;
    auto_rom = 1'b1; auto_bump = 1'b1;
    a_cs = 1'b1; b_cs = 1'b1;
    for (int k = 0; k < 200 && ng < 10; k++) tick();
    chk("t7_grants", 32'(ng), 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t7_grant%0d_b", i), 32'(gb[i]), 32'((i % 5) == 4));
      chk($sformatf("t7_grant%0d_starve", i), 32'(gs[i]), 32'((i % 5) == 4));
    end
    auto_rom = 1'b0; auto_bump = 1'b0;
    a_cs = 1'b0; b_cs = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
